// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module   : game_pkg
// Purpose  : Shared types and constants for the board cell-action logic.
//            Holds the cell-state encoding stored in the board RAM, the click
//            operation type, the sequencer FSM states, and the default widths.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package game_pkg;

  localparam int IDX_W = 5;
  localparam int CNT_W = 10;

  // State field of a board RAM word (the mine bit sits above it).
  typedef enum logic [1:0] {
    HIDDEN   = 2'b00,
    FLAGGED  = 2'b01,
    REVEALED = 2'b10
  } cell_state_e;

  typedef enum logic {
    REVEAL = 1'b0,
    TOGGLE = 1'b1
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_READ    = 3'd2,
    ST_WAIT    = 3'd3,
    ST_DECIDE  = 3'd4,
    ST_WRITE   = 3'd5,
    ST_RELEASE = 3'd6
  } state_e;

endpackage : game_pkg
`default_nettype wire

// File: rtl/cell_action_ctl_click_edge.sv
`default_nettype none
// ============================================================================
// Module   : click_edge
// Purpose  : Registers the reveal/flag request levels once and produces a
//            single-cycle click pulse on a rising edge of either. When both
//            rise together, the reveal operation takes priority.
// Ports    : clk_i    - clock
//            rst_ni   - asynchronous active-low reset
//            bomb_i   - reveal request level
//            flag_i   - flag request level
//            click_o  - rising edge seen on either request this cycle
//            op_o     - operation for this click (REVEAL over TOGGLE)
// Revision : 1.0 - initial release
// ============================================================================
module click_edge
  import game_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic bomb_i,
  input  logic flag_i,
  output logic click_o,
  output op_e  op_o
);

  logic bomb_q;
  logic flag_q;
  logic rise_bomb;
  logic rise_flag;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bomb_q <= 1'b0;
      flag_q <= 1'b0;
    end else begin
      bomb_q <= bomb_i;
      flag_q <= flag_i;
    end
  end

  // Edge is taken against the live input so the FSM can leave IDLE one
  // cycle after the request rises.
  assign rise_bomb = bomb_i & ~bomb_q;
  assign rise_flag = flag_i & ~flag_q;
  assign click_o   = rise_bomb | rise_flag;
  assign op_o      = rise_bomb ? REVEAL : TOGGLE;

endmodule : click_edge
`default_nettype wire

// File: rtl/cell_action_ctl.sv
`default_nettype none
// ============================================================================
// Module   : cell_action_ctl
// Purpose  : Turns reveal/flag clicks into read-modify-write operations on the
//            shared board status RAM, applies the per-cell game rules and
//            maintains the flags-left and revealed-cell counters.
// Config   : CELL_FLAG_LIMIT_EN - when defined, flagging a hidden cell with no
//            flags left is refused (no write); otherwise the flag is written
//            and flags_left stays saturated at zero.
// Ports    : clk, rst (async active-low)
//            bomb, flag, button_index_x/y, game_active  - click inputs
//            mine_num, new_game                          - counter reload
//            mem_req/mem_gnt/mem_addr/mem_rd/mem_rdata/
//            mem_wr/mem_wdata                            - RAM port
//            busy, explode, flags_left, reveal_cnt       - status
// Revision : 1.0 - initial release
// ============================================================================
module cell_action_ctl #(
  parameter int IDX_W = game_pkg::IDX_W,
  parameter int CNT_W = game_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               bomb,
  input  logic               flag,
  input  logic [IDX_W-1:0]   button_index_x,
  input  logic [IDX_W-1:0]   button_index_y,
  input  logic               game_active,
  input  logic [CNT_W-1:0]   mine_num,
  input  logic               new_game,
  output logic               mem_req,
  input  logic               mem_gnt,
  output logic [2*IDX_W-1:0] mem_addr,
  output logic               mem_rd,
  input  logic [2:0]         mem_rdata,
  output logic               mem_wr,
  output logic [1:0]         mem_wdata,
  output logic               busy,
  output logic               explode,
  output logic [CNT_W-1:0]   flags_left,
  output logic [CNT_W-1:0]   reveal_cnt
);

  import game_pkg::*;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] x_q, y_q;
  op_e              op_q;
  logic [2:0]       rdata_q;
  logic [1:0]       wdata_q;
  logic             explode_q;
  logic [CNT_W-1:0] flags_q, reveal_q;

  logic             click;
  op_e              click_op;
  logic             accept;

  // Rule outcome for the captured cell word.
  logic             do_write;
  cell_state_e      new_state;
  logic             boom;
  logic             inc_rev;
  logic             inc_flag;
  logic             dec_flag;

  click_edge u_click_edge (
    .clk_i   (clk),
    .rst_ni  (rst),
    .bomb_i  (bomb),
    .flag_i  (flag),
    .click_o (click),
    .op_o    (click_op)
  );

  assign accept = click && (state_q == ST_IDLE) && game_active &&
                  (button_index_x != '0) && (button_index_y != '0);

  // Game rules for one cell.
  always_comb begin
    do_write  = 1'b0;
    new_state = HIDDEN;
    boom      = 1'b0;
    inc_rev   = 1'b0;
    inc_flag  = 1'b0;
    dec_flag  = 1'b0;
    if (op_q == REVEAL) begin
      if (rdata_q[1:0] == HIDDEN) begin
        do_write  = 1'b1;
        new_state = REVEALED;
        boom      = rdata_q[2];
        inc_rev   = ~rdata_q[2];
      end
    end else begin
      if (rdata_q[1:0] == HIDDEN) begin
`ifdef CELL_FLAG_LIMIT_EN
        if (flags_q != '0) begin
          do_write  = 1'b1;
          new_state = FLAGGED;
          dec_flag  = 1'b1;
        end
`else
        do_write  = 1'b1;
        new_state = FLAGGED;
        dec_flag  = (flags_q != '0);
`endif
      end else if (rdata_q[1:0] == FLAGGED) begin
        do_write  = 1'b1;
        new_state = HIDDEN;
        inc_flag  = 1'b1;
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (accept)  state_d = ST_REQ;
      ST_REQ:     if (mem_gnt) state_d = ST_READ;
      ST_READ:    state_d = ST_WAIT;
      ST_WAIT:    state_d = ST_DECIDE;
      ST_DECIDE:  state_d = do_write ? ST_WRITE : ST_RELEASE;
      ST_WRITE:   state_d = ST_RELEASE;
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs. Strobes are decoded from state so an async reset drops
  // them immediately, before any write can reach the RAM.
  always_comb begin
    busy    = (state_q != ST_IDLE);
    mem_req = (state_q == ST_REQ) || (state_q == ST_READ) || (state_q == ST_WAIT) ||
              (state_q == ST_DECIDE) || (state_q == ST_WRITE);
    mem_rd  = (state_q == ST_READ);
    mem_wr  = (state_q == ST_WRITE);
  end

  // Operation context and RAM data path.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q       <= '0;
      y_q       <= '0;
      op_q      <= REVEAL;
      rdata_q   <= '0;
      wdata_q   <= '0;
      explode_q <= 1'b0;
    end else begin
      explode_q <= 1'b0;
      if (accept) begin
        x_q  <= button_index_x;
        y_q  <= button_index_y;
        op_q <= click_op;
      end
      if (state_q == ST_WAIT) rdata_q <= mem_rdata;
      if (state_q == ST_DECIDE) begin
        wdata_q   <= new_state;
        explode_q <= boom;
      end
    end
  end

  // Counters. A new game reloads them even while an operation is in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flags_q  <= '0;
      reveal_q <= '0;
    end else if (new_game) begin
      flags_q  <= mine_num;
      reveal_q <= '0;
    end else if (state_q == ST_DECIDE) begin
      if (inc_rev && (reveal_q != '1)) reveal_q <= reveal_q + 1'b1;
      if (dec_flag)                       flags_q  <= flags_q - 1'b1;
      if (inc_flag && (flags_q < mine_num)) flags_q <= flags_q + 1'b1;
    end
  end

  assign mem_addr   = {y_q, x_q};
  assign mem_wdata  = wdata_q;
  assign explode    = explode_q;
  assign flags_left = flags_q;
  assign reveal_cnt = reveal_q;

endmodule : cell_action_ctl
`default_nettype wire

// File: tb/tb_cell_action_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cell_action_ctl
// Purpose  : Directed self-checking bench for cell_action_ctl with a small
//            board RAM model (1-cycle read latency). Expected values are
//            hand-computed constants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cell_action_ctl;

  localparam int IDX_W = 5;
  localparam int CNT_W = 10;

  logic               clk = 1'b0;
  logic               rst;
  logic               bomb, flag;
  logic [IDX_W-1:0]   bx, by;
  logic               game_active;
  logic [CNT_W-1:0]   mine_num;
  logic               new_game;
  logic               mem_req, mem_gnt, mem_rd, mem_wr;
  logic [2*IDX_W-1:0] mem_addr;
  logic [2:0]         mem_rdata;
  logic [1:0]         mem_wdata;
  logic               busy, explode;
  logic [CNT_W-1:0]   flags_left, reveal_cnt;

  logic [2:0] ram [0:1023];
  logic       preset_en;
  logic [9:0] preset_addr;
  logic [2:0] preset_val;

  int checks   = 0;
  int failures = 0;
  int wr_count = 0;
  logic [1:0] last_wdata;
  logic [9:0] last_addr;

  always #5 clk = ~clk;

  cell_action_ctl #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .bomb           (bomb),
    .flag           (flag),
    .button_index_x (bx),
    .button_index_y (by),
    .game_active    (game_active),
    .mine_num       (mine_num),
    .new_game       (new_game),
    .mem_req        (mem_req),
    .mem_gnt        (mem_gnt),
    .mem_addr       (mem_addr),
    .mem_rd         (mem_rd),
    .mem_rdata      (mem_rdata),
    .mem_wr         (mem_wr),
    .mem_wdata      (mem_wdata),
    .busy           (busy),
    .explode        (explode),
    .flags_left     (flags_left),
    .reveal_cnt     (reveal_cnt)
  );

  // Board RAM model: mine bit is never written by the DUT.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= ram[mem_addr];
    if (mem_wr) ram[mem_addr] <= {ram[mem_addr][2], mem_wdata};
    if (preset_en) ram[preset_addr] <= preset_val;
  end

  always @(negedge clk) begin
    if (mem_wr) begin
      wr_count   <= wr_count + 1;
      last_wdata <= mem_wdata;
      last_addr  <= mem_addr;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preset(input logic [9:0] a, input logic [2:0] v);
    preset_en = 1'b1; preset_addr = a; preset_val = v;
    tick();
    preset_en = 1'b0;
  endtask

  // Raise a request for one cycle; returns in cycle 1.
  task automatic click(input logic b, input logic f, input int x, input int y);
    bx = x[IDX_W-1:0]; by = y[IDX_W-1:0];
    bomb = b; flag = f;
    tick();
    bomb = 1'b0; flag = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic pulse_new_game(input int m);
    mine_num = m[CNT_W-1:0];
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
  endtask

  initial begin
    int wr0;
    rst = 1'b0; bomb = 1'b0; flag = 1'b0; bx = '0; by = '0;
    game_active = 1'b1; mine_num = '0; new_game = 1'b0; mem_gnt = 1'b1;
    preset_en = 1'b0; preset_addr = '0; preset_val = '0;
    repeat (3) tick();

    // Reset state
    check("rst_req",    {31'd0, mem_req}, 0);
    check("rst_busy",   {31'd0, busy}, 0);
    check("rst_flags",  {22'd0, flags_left}, 0);
    check("rst_reveal", {22'd0, reveal_cnt}, 0);
    check("rst_addr",   {22'd0, mem_addr}, 0);
    rst = 1'b1;
    tick();
    pulse_new_game(2);
    check("ng_flags", {22'd0, flags_left}, 2);

    // Reveal safe hidden cell (3,4): cycle-accurate timeline
    preset(10'h083, 3'b000);
    wr0 = wr_count;
    click(1'b1, 1'b0, 3, 4);                       // cycle 1
    check("c1_req",  {31'd0, mem_req}, 1);
    check("c1_addr", {22'd0, mem_addr}, 32'h083);
    tick();                                        // cycle 2
    check("c2_rd", {31'd0, mem_rd}, 1);
    tick(); tick();                                // cycle 4
    check("c4_wr", {31'd0, mem_wr}, 0);
    tick();                                        // cycle 5
    check("c5_wr",     {31'd0, mem_wr}, 1);
    check("c5_wdata",  {30'd0, mem_wdata}, 2);
    check("c5_reveal", {22'd0, reveal_cnt}, 1);
    check("c5_explode",{31'd0, explode}, 0);
    tick();                                        // cycle 6
    check("c6_req",  {31'd0, mem_req}, 0);
    check("c6_busy", {31'd0, busy}, 1);
    tick();                                        // cycle 7
    check("c7_busy", {31'd0, busy}, 0);
    check("ram_083", {29'd0, ram[10'h083]}, 3'b010);
    check("wr_once", wr_count - wr0, 1);

    // Same cell with a mine, hidden again
    preset(10'h083, 3'b100);
    click(1'b1, 1'b0, 3, 4);
    repeat (3) tick();                             // cycle 4
    check("m4_explode", {31'd0, explode}, 0);
    tick();                                        // cycle 5
    check("m5_explode", {31'd0, explode}, 1);
    tick();
    check("m6_explode", {31'd0, explode}, 0);
    wait_idle();
    check("m_reveal", {22'd0, reveal_cnt}, 1);
    check("m_ram",    {29'd0, ram[10'h083]}, 3'b110);

    // Flag limit: mine_num=2, three hidden cells
    pulse_new_game(2);
    check("ng_reveal", {22'd0, reveal_cnt}, 0);
    preset(10'h021, 3'b000);
    preset(10'h022, 3'b000);
    preset(10'h023, 3'b000);
    click(1'b0, 1'b1, 1, 1); wait_idle();
    check("f1_flags", {22'd0, flags_left}, 1);
    check("f1_wdata", {30'd0, last_wdata}, 1);
    click(1'b0, 1'b1, 2, 1); wait_idle();
    check("f2_flags", {22'd0, flags_left}, 0);
    wr0 = wr_count;
    click(1'b0, 1'b1, 3, 1); wait_idle();
    check("f3_flags", {22'd0, flags_left}, 0);
`ifdef CELL_FLAG_LIMIT_EN
    check("f3_wr",  wr_count - wr0, 0);
    check("f3_ram", {29'd0, ram[10'h023]}, 3'b000);
`else
    check("f3_wr",  wr_count - wr0, 1);
    check("f3_ram", {29'd0, ram[10'h023]}, 3'b001);
`endif

    // Flag then unflag (4,2) -> addr 0x044
    pulse_new_game(2);
    preset(10'h044, 3'b000);
    click(1'b0, 1'b1, 4, 2); wait_idle();
    check("t1_wdata", {30'd0, last_wdata}, 1);
    check("t1_flags", {22'd0, flags_left}, 1);
    click(1'b0, 1'b1, 4, 2); wait_idle();
    check("t2_wdata", {30'd0, last_wdata}, 0);
    check("t2_flags", {22'd0, flags_left}, 2);
    check("t2_ram",   {29'd0, ram[10'h044]}, 3'b000);

    // Delayed grant with a second click dropped
    preset(10'h065, 3'b000);
    preset(10'h066, 3'b000);
    mem_gnt = 1'b0;
    wr0 = wr_count;
    click(1'b1, 1'b0, 5, 3);
    tick(); tick();
    click(1'b1, 1'b0, 6, 3);
    tick();
    check("g_busy", {31'd0, busy}, 1);
    check("g_req",  {31'd0, mem_req}, 1);
    check("g_addr", {22'd0, mem_addr}, 32'h065);
    check("g_rd",   {31'd0, mem_rd}, 0);
    mem_gnt = 1'b1;
    wait_idle();
    repeat (4) tick();
    check("g_wr",    wr_count - wr0, 1);
    check("g_last",  {22'd0, last_addr}, 32'h065);
    check("g_ram66", {29'd0, ram[10'h066]}, 3'b000);
    check("g_idle",  {31'd0, busy}, 0);
    check("g_rev",   {22'd0, reveal_cnt}, 1);

    // Async reset during WAIT
    preset(10'h087, 3'b000);
    wr0 = wr_count;
    click(1'b1, 1'b0, 7, 4);
    tick(); tick();                                // cycle 3: WAIT
    rst = 1'b0;
    #1;
    check("r_req",    {31'd0, mem_req}, 0);
    check("r_flags",  {22'd0, flags_left}, 0);
    check("r_reveal", {22'd0, reveal_cnt}, 0);
    tick();
    rst = 1'b1;
    repeat (5) tick();
    check("r_wr",  wr_count - wr0, 0);
    check("r_ram", {29'd0, ram[10'h087]}, 3'b000);

    // Rejected clicks
    click(1'b1, 1'b0, 0, 3);
    check("z_req", {31'd0, mem_req}, 0);
    tick();
    game_active = 1'b0;
    click(1'b1, 1'b0, 2, 2);
    check("ga_req", {31'd0, mem_req}, 0);
    game_active = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_cell_action_ctl
`default_nettype wire
